// File: rtl/cpu_pcu_pkg.sv
// Shared encodings for the MCS8 program-counter unit.
package cpu_pcu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC  = 3'd0;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd1;
  localparam logic [OP_W-1:0] OP_CALL = 3'd2;
  localparam logic [OP_W-1:0] OP_RET  = 3'd3;
  localparam logic [OP_W-1:0] OP_RST  = 3'd4;

  // RST n jumps to n*8
  localparam int unsigned RST_VEC_SHIFT = 3;

endpackage

// File: rtl/cpu_ras.sv
// Circular return-address stack: overwrites oldest on overflow, returns stale entry on underflow.
module cpu_ras #(
  parameter  int unsigned PC_W  = 14,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned SP_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W = SP_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [PC_W-1:0]  wdata,
  output logic [PC_W-1:0]  top_c,
  output logic [SP_W-1:0]  sp,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf
);

  logic [PC_W-1:0] mem [DEPTH];
  logic            full_c;
  logic            empty_c;

  assign full_c  = (cnt == CNT_W'(DEPTH));
  assign empty_c = (cnt == '0);
  assign top_c   = mem[sp - SP_W'(1)];

  // Error flags: a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push) begin
        mem[sp] <= wdata;
        sp      <= sp + SP_W'(1);
        if (!full_c) cnt <= cnt + CNT_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
        if (!empty_c) cnt <= cnt - CNT_W'(1);
      end
      ovf <= (ovf & ~clr_err) | (push & full_c);
      udf <= (udf & ~clr_err) | (pop & empty_c);
    end
  end

endmodule

// File: rtl/cpu_pcu.sv
// Program-counter unit: PC register, condition evaluation, next-PC mux and return stack.
module cpu_pcu
  import cpu_pcu_pkg::*;
#(
  parameter  int unsigned     PC_W    = 14,
  parameter  int unsigned     DEPTH   = 8,
  parameter  int unsigned     FLAG_W  = 4,
  parameter  logic [PC_W-1:0] RST_VEC = '0,
  localparam int unsigned     SEL_W   = (FLAG_W > 1) ? $clog2(FLAG_W) : 1,
  localparam int unsigned     SP_W    = $clog2(DEPTH),
  localparam int unsigned     CNT_W   = SP_W + 1
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              EN_I,
  input  logic [OP_W-1:0]   OP_I,
  input  logic              COND_EN_I,
  input  logic [SEL_W-1:0]  COND_SEL_I,
  input  logic              COND_VAL_I,
  input  logic [FLAG_W-1:0] FLAGS_I,
  input  logic [PC_W-1:0]   TGT_I,
  input  logic [2:0]        RSTN_I,
  input  logic              CLR_ERR_I,
  output logic [PC_W-1:0]   PC_O,
  output logic              TAKEN_O,
  output logic [SP_W-1:0]   SP_O,
  output logic [CNT_W-1:0]  CNT_O,
  output logic              FULL_O,
  output logic              EMPTY_O,
  output logic              OVF_O,
  output logic              UDF_O
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] ras_top;
  logic            taken_q;
  logic            taken_nxt;
  logic            cond_ok;
  logic            push_c;
  logic            pop_c;

  assign pc_inc  = pc_q + PC_W'(1);
  assign cond_ok = !COND_EN_I || (FLAGS_I[COND_SEL_I] == COND_VAL_I);

  // Next-PC select; stack side effects only while advancing
  always_comb begin
    pc_nxt    = pc_inc;
    taken_nxt = 1'b0;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    case (OP_I)
      OP_JMP: if (cond_ok) begin
        pc_nxt    = TGT_I;
        taken_nxt = 1'b1;
      end
      OP_CALL: if (cond_ok) begin
        pc_nxt    = TGT_I;
        taken_nxt = 1'b1;
        push_c    = 1'b1;
      end
      OP_RET: if (cond_ok) begin
        pc_nxt    = ras_top;
        taken_nxt = 1'b1;
        pop_c     = 1'b1;
      end
      OP_RST: begin
        pc_nxt    = PC_W'(RSTN_I) << RST_VEC_SHIFT;
        taken_nxt = 1'b1;
        push_c    = 1'b1;
      end
      default: ;
    endcase
    if (!EN_I) begin
      push_c = 1'b0;
      pop_c  = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      pc_q    <= RST_VEC;
      taken_q <= 1'b0;
    end else if (EN_I) begin
      pc_q    <= pc_nxt;
      taken_q <= taken_nxt;
    end
  end

  cpu_ras #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk     (CLK_I),
    .rst     (RST_I),
    .push    (push_c),
    .pop     (pop_c),
    .clr_err (CLR_ERR_I),
    .wdata   (pc_inc),
    .top_c   (ras_top),
    .sp      (SP_O),
    .cnt     (CNT_O),
    .ovf     (OVF_O),
    .udf     (UDF_O)
  );

  assign PC_O    = pc_q;
  assign TAKEN_O = taken_q;
  assign FULL_O  = (CNT_O == CNT_W'(DEPTH));
  assign EMPTY_O = (CNT_O == '0);

endmodule

// File: tb/tb_cpu_pcu.sv
// Bench for cpu_pcu: two configurations (14b/8 and 16b/16) driven in lockstep against a reference model.
module tb_cpu_pcu;
  import cpu_pcu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic        cond_en;
  logic [1:0]  cond_sel;
  logic        cond_val;
  logic [3:0]  flags;
  logic [15:0] tgt;
  logic [2:0]  rstn;
  logic        clr_err;

  logic [13:0] pc_a;  logic taken_a; logic [2:0] sp_a; logic [3:0] cnt_a;
  logic        full_a, empty_a, ovf_a, udf_a;
  logic [15:0] pc_b;  logic taken_b; logic [3:0] sp_b; logic [4:0] cnt_b;
  logic        full_b, empty_b, ovf_b, udf_b;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  cpu_pcu #(.PC_W(14), .DEPTH(8), .FLAG_W(4), .RST_VEC(14'h0000)) u_a (
    .CLK_I(clk), .RST_I(rst), .EN_I(en), .OP_I(op), .COND_EN_I(cond_en),
    .COND_SEL_I(cond_sel), .COND_VAL_I(cond_val), .FLAGS_I(flags), .TGT_I(tgt[13:0]),
    .RSTN_I(rstn), .CLR_ERR_I(clr_err), .PC_O(pc_a), .TAKEN_O(taken_a), .SP_O(sp_a),
    .CNT_O(cnt_a), .FULL_O(full_a), .EMPTY_O(empty_a), .OVF_O(ovf_a), .UDF_O(udf_a));

  cpu_pcu #(.PC_W(16), .DEPTH(16), .FLAG_W(4), .RST_VEC(16'h1234)) u_b (
    .CLK_I(clk), .RST_I(rst), .EN_I(en), .OP_I(op), .COND_EN_I(cond_en),
    .COND_SEL_I(cond_sel), .COND_VAL_I(cond_val), .FLAGS_I(flags), .TGT_I(tgt),
    .RSTN_I(rstn), .CLR_ERR_I(clr_err), .PC_O(pc_b), .TAKEN_O(taken_b), .SP_O(sp_b),
    .CNT_O(cnt_b), .FULL_O(full_b), .EMPTY_O(empty_b), .OVF_O(ovf_b), .UDF_O(udf_b));

  // DUT observations gathered per configuration
  logic [31:0] d_pc [2];
  logic [31:0] d_sp [2];
  logic [31:0] d_cnt [2];
  logic        d_tk [2], d_ovf [2], d_udf [2], d_full [2], d_empty [2];

  always_comb begin
    d_pc[0] = 32'(pc_a);  d_sp[0] = 32'(sp_a);  d_cnt[0] = 32'(cnt_a);
    d_tk[0] = taken_a; d_ovf[0] = ovf_a; d_udf[0] = udf_a; d_full[0] = full_a; d_empty[0] = empty_a;
    d_pc[1] = 32'(pc_b);  d_sp[1] = 32'(sp_b);  d_cnt[1] = 32'(cnt_b);
    d_tk[1] = taken_b; d_ovf[1] = ovf_b; d_udf[1] = udf_b; d_full[1] = full_b; d_empty[1] = empty_b;
  end

  // Reference model
  int unsigned PCW [2] = '{14, 16};
  int unsigned DEP [2] = '{8, 16};
  logic [31:0] RV  [2] = '{32'h0, 32'h1234};

  logic [31:0] m_pc [2];
  logic [31:0] m_sp [2];
  logic [31:0] m_cnt [2];
  logic [31:0] m_stk [2][16];
  logic        m_tk [2], m_ovf [2], m_udf [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = RV[i]; m_sp[i] = 0; m_cnt[i] = 0;
      m_tk[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
      for (int j = 0; j < 16; j++) m_stk[i][j] = 0;
    end
  endtask

  task automatic model_push(input int i, input logic [31:0] d);
    m_stk[i][m_sp[i]] = d;
    m_sp[i] = (m_sp[i] + 1) % DEP[i];
    if (m_cnt[i] == DEP[i]) m_ovf[i] = 1'b1;
    else m_cnt[i] = m_cnt[i] + 1;
  endtask

  task automatic model_pop(input int i, output logic [31:0] d);
    m_sp[i] = (m_sp[i] + DEP[i] - 1) % DEP[i];
    d = m_stk[i][m_sp[i]];
    if (m_cnt[i] == 0) m_udf[i] = 1'b1;
    else m_cnt[i] = m_cnt[i] - 1;
  endtask

  task automatic model_step();
    logic [31:0] mask, inc, r;
    logic        tk;
    for (int i = 0; i < 2; i++) begin
      mask = (32'h1 << PCW[i]) - 1;
      if (clr_err) begin m_ovf[i] = 1'b0; m_udf[i] = 1'b0; end
      if (en) begin
        inc = (m_pc[i] + 1) & mask;
        tk  = !cond_en || (flags[cond_sel] == cond_val);
        if (op == 3'd4) begin
          model_push(i, inc); m_pc[i] = 32'(rstn) * 8; m_tk[i] = 1'b1;
        end else if (tk && op == 3'd1) begin
          m_pc[i] = 32'(tgt) & mask; m_tk[i] = 1'b1;
        end else if (tk && op == 3'd2) begin
          model_push(i, inc); m_pc[i] = 32'(tgt) & mask; m_tk[i] = 1'b1;
        end else if (tk && op == 3'd3) begin
          model_pop(i, r); m_pc[i] = r; m_tk[i] = 1'b1;
        end else begin
          m_pc[i] = inc; m_tk[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_op(input logic [2:0] o, input logic [15:0] t);
    en = 1'b1; op = o; tgt = t; cond_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; op = OP_INC; cond_en = 1'b0; cond_sel = '0; cond_val = 1'b0;
    flags = '0; tgt = '0; rstn = '0; clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vec++;
      if (d_pc[i] !== RV[i] || d_sp[i] !== 0 || d_cnt[i] !== 0 || d_tk[i] !== 1'b0 ||
          d_ovf[i] !== 1'b0 || d_udf[i] !== 1'b0 || d_empty[i] !== 1'b1 || d_full[i] !== 1'b0) begin
        err++;
        $display("FAIL reset[%0d]: pc=%h sp=%0d cnt=%0d tk=%b ovf=%b udf=%b e=%b f=%b, required pc=%h rest 0, empty=1",
                 i, d_pc[i], d_sp[i], d_cnt[i], d_tk[i], d_ovf[i], d_udf[i], d_empty[i], d_full[i], RV[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_inc();
    set_op(OP_INC, '0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      vec++;
      if (pc_a !== 14'(k) || pc_b !== 16'(32'h1234 + k)) begin
        err++; $display("FAIL inc step %0d: pc_a=%h pc_b=%h, required %h %h", k, pc_a, pc_b, k, 32'h1234 + k);
      end
    end
    set_op(OP_JMP, 16'hFFFF); tick();
    set_op(OP_INC, '0); tick();
    vec++;
    if (pc_a !== 14'h0000 || pc_b !== 16'h0000 || taken_a !== 1'b0) begin
      err++; $display("FAIL inc wrap: pc_a=%h pc_b=%h taken=%b, required 0 0 0", pc_a, pc_b, taken_a);
    end
  endtask

  task automatic test_cond();
    set_op(OP_JMP, 16'h0123);
    flags = 4'b0010; cond_en = 1'b1; cond_sel = 2'd1; cond_val = 1'b1;
    tick();
    vec++;
    if (pc_a !== 14'h0123 || taken_a !== 1'b1 || pc_b !== 16'h0123 || taken_b !== 1'b1) begin
      err++; $display("FAIL cond taken: pc=%h/%h tk=%b/%b, required 0123 taken", pc_a, pc_b, taken_a, taken_b);
    end
    cond_val = 1'b0;
    tick();
    vec++;
    if (pc_a !== 14'h0124 || taken_a !== 1'b0 || pc_b !== 16'h0124 || taken_b !== 1'b0) begin
      err++; $display("FAIL cond not taken: pc=%h/%h tk=%b/%b, required 0124 not taken", pc_a, pc_b, taken_a, taken_b);
    end
  endtask

  task automatic test_call_ret();
    logic [15:0] tg [4]  = '{16'h0200, 16'h0300, 16'h0000, 16'h0000};
    logic [2:0]  os [4]  = '{3'd2, 3'd2, 3'd3, 3'd3};
    logic [13:0] ep [4]  = '{14'h0200, 14'h0300, 14'h0201, 14'h0011};
    logic [3:0]  ec [4]  = '{4'd1, 4'd2, 4'd1, 4'd0};
    set_op(OP_JMP, 16'h0010); tick();
    for (int k = 0; k < 4; k++) begin
      set_op(os[k], tg[k]); tick();
      vec++;
      if (pc_a !== ep[k] || cnt_a !== ec[k] || taken_a !== 1'b1 || pc_b !== 16'(ep[k])) begin
        err++; $display("FAIL call_ret step %0d: pc=%h cnt=%0d tk=%b pc_b=%h, required pc=%h cnt=%0d",
                        k, pc_a, cnt_a, taken_a, pc_b, ep[k], ec[k]);
      end
    end
  endtask

  task automatic test_ovf_udf();
    for (int k = 0; k < 9; k++) begin set_op(OP_CALL, 16'($urandom)); tick(); end
    vec++;
    if (ovf_a !== 1'b1 || cnt_a !== 4'd8 || sp_a !== 3'd1 || full_a !== 1'b1 ||
        ovf_b !== 1'b0 || cnt_b !== 5'd9 || sp_b !== 4'd9) begin
      err++; $display("FAIL overflow: a ovf=%b cnt=%0d sp=%0d full=%b b ovf=%b cnt=%0d sp=%0d, required 1 8 1 1 / 0 9 9",
                      ovf_a, cnt_a, sp_a, full_a, ovf_b, cnt_b, sp_b);
    end
    for (int k = 0; k < 9; k++) begin
      set_op(OP_RET, '0); tick();
      vec++;
      if (udf_a !== (k == 8) || pc_a !== m_pc[0][13:0] || pc_b !== m_pc[1][15:0] || udf_b !== 1'b0) begin
        err++; $display("FAIL underflow ret %0d: udf=%b pc=%h pc_b=%h udf_b=%b, required udf=%b pc=%h pc_b=%h udf_b=0",
                        k, udf_a, pc_a, pc_b, udf_b, k == 8, m_pc[0], m_pc[1]);
      end
    end
    set_op(OP_RET, '0); clr_err = 1'b1; tick();
    vec++;
    if (udf_a !== 1'b1 || ovf_a !== 1'b0 || empty_a !== 1'b1) begin
      err++; $display("FAIL clr vs new error: udf=%b ovf=%b empty=%b, required 1 0 1", udf_a, ovf_a, empty_a);
    end
    en = 1'b0; clr_err = 1'b1; tick();
    vec++;
    if (udf_a !== 1'b0 || ovf_a !== 1'b0) begin
      err++; $display("FAIL clear while stalled: udf=%b ovf=%b, required 0 0", udf_a, ovf_a);
    end
    clr_err = 1'b0;
  endtask

  task automatic test_rst_stall();
    logic [13:0] hold;
    set_op(OP_JMP, 16'h0040); tick();
    set_op(OP_RST, '0); rstn = 3'd5; tick();
    vec++;
    if (pc_a !== 14'h0028 || taken_a !== 1'b1 || pc_b !== 16'h0028) begin
      err++; $display("FAIL rst vector: pc=%h tk=%b pc_b=%h, required 0028 1", pc_a, taken_a, pc_b);
    end
    en = 1'b0; op = OP_JMP;
    hold = pc_a;
    for (int k = 0; k < 3; k++) begin
      tgt = 16'($urandom); flags = 4'($urandom); tick();
      vec++;
      if (pc_a !== hold || taken_a !== 1'b1 || pc_b !== m_pc[1][15:0]) begin
        err++; $display("FAIL stall %0d: pc=%h tk=%b, required %h 1", k, pc_a, taken_a, hold);
      end
    end
    set_op(OP_RET, '0); tick();
    vec++;
    if (pc_a !== 14'h0041 || pc_b !== 16'h0041) begin
      err++; $display("FAIL rst return: pc=%h pc_b=%h, required 0041", pc_a, pc_b);
    end
  endtask

  task automatic test_async_reset();
    set_op(OP_CALL, 16'h0155); tick();
    #2; rst = 1'b1; #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      vec++;
      if (d_pc[i] !== RV[i] || d_cnt[i] !== 0 || d_sp[i] !== 0 || d_tk[i] !== 1'b0 || d_empty[i] !== 1'b1) begin
        err++; $display("FAIL async reset[%0d]: pc=%h cnt=%0d sp=%0d tk=%b empty=%b, required pc=%h 0 0 0 1",
                        i, d_pc[i], d_cnt[i], d_sp[i], d_tk[i], d_empty[i], RV[i]);
      end
    end
    rst = 1'b0;
    set_op(OP_INC, '0); tick();
    vec++;
    if (pc_a !== 14'h0001 || pc_b !== 16'h1235) begin
      err++; $display("FAIL post-reset inc: pc=%h pc_b=%h, required 0001 1235", pc_a, pc_b);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0); op = 3'($urandom); cond_en = 1'($urandom);
      cond_sel = 2'($urandom); cond_val = 1'($urandom); flags = 4'($urandom);
      tgt = 16'($urandom); rstn = 3'($urandom); clr_err = ($urandom_range(0, 19) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        vec++;
        if (d_pc[i] !== m_pc[i] || d_tk[i] !== m_tk[i] || d_sp[i] !== m_sp[i] || d_cnt[i] !== m_cnt[i] ||
            d_ovf[i] !== m_ovf[i] || d_udf[i] !== m_udf[i] ||
            d_full[i] !== (m_cnt[i] == DEP[i]) || d_empty[i] !== (m_cnt[i] == 0)) begin
          err++; $display("FAIL random n=%0d cfg=%0d: pc=%h tk=%b sp=%0d cnt=%0d ovf=%b udf=%b, required pc=%h tk=%b sp=%0d cnt=%0d ovf=%b udf=%b",
                          n, i, d_pc[i], d_tk[i], d_sp[i], d_cnt[i], d_ovf[i], d_udf[i],
                          m_pc[i], m_tk[i], m_sp[i], m_cnt[i], m_ovf[i], m_udf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_cond();
    test_call_ret();
    test_ovf_udf();
    test_rst_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/cpu_pcu.md
# cpu_pcu

Parametrised program-counter unit for the MCS8 pipeline, the successor to the fixed 14-bit/8-level PC. It owns the PC register and a circular return-address stack of configurable width and depth. It resolves conditional JMP/CALL/RET against a selectable status flag and implements RST-vector calls. It adds stall, overflow/underflow detection with sticky error flags, and stack-occupancy outputs; it sits between decode and fetch.

## Interface
Parameters:
- PC_W, 14, PC and stack-entry width (8..32)
- DEPTH, 8, stack entries; power of two, >= 2
- FLAG_W, 4, status flag vector width
- RST_VEC, 0, PC value after reset (PC_W bits)

Ports:
- CLK_I  in  1  clock; all state updates on rising edge
- RST_I  in  1  reset; one clock, asynchronous, active-high
- EN_I  in  1  advance; 0 = stall, PC/stack/TAKEN_O hold
- OP_I  in  3  0 INC, 1 JMP, 2 CALL, 3 RET, 4 RST; 5..7 treated as INC
- COND_EN_I  in  1  0 = unconditional op, 1 = conditional
- COND_SEL_I  in  $clog2(FLAG_W)  flag index tested
- COND_VAL_I  in  1  required flag value for "taken"
- FLAGS_I  in  FLAG_W  status flags (from ALU forwarding or status reg, muxed upstream)
- TGT_I  in  PC_W  JMP/CALL target
- RSTN_I  in  3  RST vector number n
- CLR_ERR_I  in  1  clears OVF_O/UDF_O
- PC_O  out  PC_W  current PC (registered)
- TAKEN_O  out  1  last executed op was a taken JMP/CALL/RET/RST (registered)
- SP_O  out  $clog2(DEPTH)  stack write pointer (next push slot)
- CNT_O  out  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- FULL_O / EMPTY_O  out  1  CNT_O==DEPTH / CNT_O==0 (combinational from CNT)
- OVF_O / UDF_O  out  1  sticky push-when-full / pop-when-empty

## Operation
- taken = !COND_EN_I | (FLAGS_I[COND_SEL_I] == COND_VAL_I); RST is always unconditional.
- inc = PC_O + 1 mod 2^PC_W (wraps from all-ones to 0).
- On edge with EN_I=1:
  - INC, or any not-taken op: PC <= inc; TAKEN <= 0.
  - JMP taken: PC <= TGT_I.
  - CALL taken: push inc; PC <= TGT_I.
  - RET taken: PC <= stack[SP-1]; pop.
  - RST: push inc; PC <= zero-extended {RSTN_I, 3'b000}.
- Push: stack[SP] <= data; SP <= SP+1 mod DEPTH. If CNT==DEPTH, the oldest entry is overwritten, CNT stays DEPTH, and OVF set; otherwise CNT+1.
- Pop: SP <= SP-1 mod DEPTH. If CNT==0, the stale entry at SP-1 is still returned, CNT stays 0, and UDF set; otherwise CNT-1.
- CLR_ERR_I acts regardless of EN_I. If set in the same cycle as a new error, the error wins (flag remains 1).
- EN_I=0: no change to PC, SP, CNT, stack or TAKEN_O; FLAGS_I/TGT_I ignored.

## Timing
- Reset values: PC_O=RST_VEC, SP_O=0, CNT_O=0, TAKEN_O=0, OVF_O=0, UDF_O=0, all stack entries 0. EMPTY_O=1, FULL_O=0.
- Reset asserted mid-operation clears immediately, no clock needed; the first update occurs on the first rising edge after RST_I deasserts.
- Latency: one cycle. Inputs sampled at edge k; PC_O, TAKEN_O and stack outputs valid after edge k.
- No combinational path from any input to any output.
- Stack read for RET uses the pre-edge SP; push and pop never coincide (one op per cycle).

## Structure
- Package cpu_pcu_pkg: OP_* encodings (3-bit localparams) and the RST vector shift (3).
- Sub-module cpu_ras: circular stack with push/pop/data/SP/CNT/OVF/UDF, parametrised by PC_W and DEPTH. cpu_pcu holds the PC register, condition evaluation and next-PC mux.

## Test plan
- Reset/INC: release RST_I, EN_I=1, OP=INC for 3 cycles -> PC_O 0,1,2,3; PC=0x3FFF + INC -> 0x0000.
- Conditional: FLAGS=4'b0010, COND_EN=1, SEL=1, VAL=1, JMP TGT=0x0123 -> PC=0x0123, TAKEN=1; same with VAL=0 -> PC+1, TAKEN=0.
- CALL/RET nest: at PC=0x0010 CALL 0x0200, then CALL 0x0300, RET, RET -> PC 0x0200, 0x0300, 0x0201, 0x0011; CNT 1,2,1,0.
- Overflow/underflow (DEPTH=8): 9 CALLs -> OVF=1, CNT=8, SP wraps to 1; then 9 RETs -> 9th sets UDF=1. CLR_ERR_I clears both next edge.
- RST n and stall: RSTN=5 at PC=0x0040 -> PC=0x0028, top=0x0041. Hold EN_I=0 with JMP applied -> PC unchanged.
- Async reset mid-CALL: assert RST_I between edges -> outputs at reset values before the next edge. Repeat with PC_W=16, DEPTH=16.
